// File: rtl/psum_drain_pkg.sv
// Shared sizes and FSM encoding for the psum drain path.
// Imported by the drain top and its skew delay lines.
package psum_drain_pkg;

  localparam int PD_ARRAY_SIZE = 4;
  localparam int PD_DATA_SIZE  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } drain_state_t;

  // Counter must hold start_delay + ARRAY_SIZE - 1 and num_rows - 1 without wrap.
  function automatic int cnt_width(input int delay_w, input int rows_w, input int array_size);
    int base_w;
    base_w = (delay_w > rows_w) ? delay_w : rows_w;
    return base_w + $clog2(array_size + 1) + 1;
  endfunction

endpackage

// File: rtl/psum_drain_skew_delay_line.sv
// DEPTH-stage shift register for one psum lane; the last stage only loads
// when last_en is high so it can hold the value presented to the SRAM.
module skew_delay_line
  import psum_drain_pkg::*;
#(
  parameter int DEPTH     = 1,
  parameter int DATA_SIZE = PD_DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 last_en,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout
);

  logic [DATA_SIZE-1:0] stage    [DEPTH];
  logic [DATA_SIZE-1:0] stage_in [DEPTH];

  genvar g;
  for (g = 0; g < DEPTH; g++) begin : g_src
    if (g == 0) begin : g_head
      assign stage_in[g] = din;
    end else begin : g_body
      assign stage_in[g] = stage[g-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        stage[i] <= stage_in[i];
      end
      if (last_en) begin
        stage[DEPTH-1] <= stage_in[DEPTH-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/psum_drain.sv
// Drains skewed partial sums from the bottom of the PE array, de-skews them,
// optionally applies ReLU and writes one row per cycle to the output SRAM.
//
//   state   | meaning
//   IDLE    | waiting for start
//   WAIT    | counting down until the first row is fully de-skewed
//   COLLECT | one SRAM write per cycle, num_rows cycles
//   DONE    | one-cycle done pulse, then back to IDLE
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int ARRAY_SIZE  = PD_ARRAY_SIZE,
  parameter int DATA_SIZE   = PD_DATA_SIZE,
  parameter int ADDR_WIDTH  = 10,
  parameter int DELAY_WIDTH = 8,
  parameter int ROWS_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [DELAY_WIDTH-1:0]           start_delay,
  input  logic [ROWS_WIDTH-1:0]            num_rows,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic                             relu_en,
  input  logic [ARRAY_SIZE*DATA_SIZE-1:0]  psum_in,
  output logic                             sram_wen,
  output logic [ADDR_WIDTH-1:0]            sram_addr,
  output logic [ARRAY_SIZE*DATA_SIZE-1:0]  sram_wdata,
  output logic                             busy,
  output logic                             done
);

  localparam int CNT_W = cnt_width(DELAY_WIDTH, ROWS_WIDTH, ARRAY_SIZE);

  drain_state_t          state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [ROWS_WIDTH-1:0] rows_lat;
  logic [ADDR_WIDTH-1:0] base_lat;
  logic                  relu_lat;
  logic                  latch_en;
  logic                  last_en;
  logic                  addr_load;
  logic                  addr_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    latch_en  = 1'b0;
    last_en   = 1'b0;
    addr_load = 1'b0;
    addr_inc  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    sram_wen  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          latch_en = 1'b1;
          if (num_rows != '0) begin
            state_nx = ST_WAIT;
            cnt_nx   = CNT_W'(start_delay) + CNT_W'(ARRAY_SIZE - 1);
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (cnt == '0) begin
          state_nx  = ST_COLLECT;
          cnt_nx    = CNT_W'(rows_lat) - CNT_W'(1);
          last_en   = 1'b1;
          addr_load = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ST_COLLECT: begin
        busy     = 1'b1;
        sram_wen = 1'b1;
        if (cnt == '0) begin
          state_nx = ST_DONE;
        end else begin
          cnt_nx   = cnt - CNT_W'(1);
          last_en  = 1'b1;
          addr_inc = 1'b1;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_lat <= '0;
      base_lat <= '0;
      relu_lat <= 1'b0;
    end else if (latch_en) begin
      rows_lat <= num_rows;
      base_lat <= base_addr;
      relu_lat <= relu_en;
    end
  end

  // Address register loads at the edge before each write so it lines up with sram_wen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr <= '0;
    end else if (addr_load) begin
      sram_addr <= base_lat;
    end else if (addr_inc) begin
      sram_addr <= sram_addr + ADDR_WIDTH'(1);
    end
  end

  logic [DATA_SIZE-1:0] lane_in  [ARRAY_SIZE];
  logic [DATA_SIZE-1:0] lane_out [ARRAY_SIZE];

  genvar c;
  for (c = 0; c < ARRAY_SIZE; c++) begin : g_lane
    assign lane_in[c] = (relu_lat && psum_in[c*DATA_SIZE + DATA_SIZE - 1])
                        ? '0 : psum_in[c*DATA_SIZE +: DATA_SIZE];

    skew_delay_line #(
      .DEPTH     (ARRAY_SIZE - c),
      .DATA_SIZE (DATA_SIZE)
    ) u_skew (
      .clk     (clk),
      .rst     (rst),
      .last_en (last_en),
      .din     (lane_in[c]),
      .dout    (lane_out[c])
    );

    assign sram_wdata[c*DATA_SIZE +: DATA_SIZE] = lane_out[c];
  end

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: the driver pushes expected SRAM writes,
// a negedge monitor pops and compares them as the DUT issues writes.
module tb_psum_drain;

  localparam int A  = 4;
  localparam int DS = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    start_delay = '0;
  logic [7:0]    num_rows = '0;
  logic [AW-1:0] base_addr = '0;
  logic          relu_en = 1'b0;
  logic [A*DS-1:0] psum_in = '0;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [A*DS-1:0] sram_wdata;
  logic          busy;
  logic          done;

  psum_drain dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_delay (start_delay),
    .num_rows    (num_rows),
    .base_addr   (base_addr),
    .relu_en     (relu_en),
    .psum_in     (psum_in),
    .sram_wen    (sram_wen),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  int            q_cyc  [$];
  logic [AW-1:0] q_addr [$];
  logic [A*DS-1:0] q_data [$];
  int exp_done_cyc = -1;
  int busy_lo = 0;
  int busy_hi = -1;

  logic [DS-1:0] row_data [256][A];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [A*DS-1:0] exp_row(input int r, input bit relu);
    logic [A*DS-1:0] res;
    logic [DS-1:0]   v;
    res = '0;
    for (int c = 0; c < A; c++) begin
      v = row_data[r][c];
      if (relu && $signed(v) < 0) v = '0;
      res[c*DS +: DS] = v;
    end
    return res;
  endfunction

  // Monitor: scoreboard pop on every write, plus busy/done against the expected windows.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 64'(busy), 64'((cyc >= busy_lo) && (cyc <= busy_hi)));
      check("done", 64'(done), 64'(cyc == exp_done_cyc));
      if (sram_wen) begin
        if (q_cyc.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write at cycle %0d: addr %h data %h, no write expected",
                   cyc, sram_addr, sram_wdata);
        end else begin
          check("write_cycle", 64'(cyc), 64'(q_cyc.pop_front()));
          check("write_addr", 64'(sram_addr), 64'(q_addr.pop_front()));
          check("write_data", 64'(sram_wdata), 64'(q_data.pop_front()));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_wen"},   64'(sram_wen),   64'(0));
    check({tag, "_addr"},  64'(sram_addr),  64'(0));
    check({tag, "_wdata"}, 64'(sram_wdata), 64'(0));
    check({tag, "_busy"},  64'(busy),       64'(0));
    check({tag, "_done"},  64'(done),       64'(0));
  endtask

  task automatic run_drain(input int d, input int n, input logic [AW-1:0] base,
                           input bit relu, input int restart_k, input int abort_k);
    int t0;
    logic [A*DS-1:0] p;
    @(negedge clk);
    t0 = cyc + 1;
    q_cyc.delete(); q_addr.delete(); q_data.delete();
    if (n == 0) begin
      exp_done_cyc = t0;
      busy_lo = 0;
      busy_hi = -1;
    end else begin
      for (int r = 0; r < n; r++) begin
        q_cyc.push_back(t0 + d + r + A);
        q_addr.push_back(AW'((int'(base) + r) % (1 << AW)));
        q_data.push_back(exp_row(r, relu));
      end
      exp_done_cyc = t0 + d + n + A;
      busy_lo = t0;
      busy_hi = t0 + d + n + A - 1;
    end
    start = 1'b1;
    start_delay = 8'(d);
    num_rows = 8'(n);
    base_addr = base;
    relu_en = relu;
    psum_in = {$urandom, $urandom};
    for (int k = 0; k <= d + n + A + 1; k++) begin
      @(negedge clk);
      start = (k == restart_k);
      start_delay = 8'($urandom);
      num_rows = 8'($urandom);
      base_addr = AW'($urandom);
      relu_en = 1'($urandom);
      for (int c = 0; c < A; c++) begin
        int r;
        r = k - d - c;
        if (r >= 0 && r < n) p[c*DS +: DS] = row_data[r][c];
        else p[c*DS +: DS] = DS'($urandom);
      end
      psum_in = p;
      if (k + 1 == abort_k) begin
        @(posedge clk);
        #2;
        rst = 1'b1;
        start = 1'b0;
        q_cyc.delete(); q_addr.delete(); q_data.delete();
        exp_done_cyc = -1;
        busy_hi = -1;
        #1;
        check_all_zero("abort_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (d + n + A) @(negedge clk);
        return;
      end
    end
    start = 1'b0;
    check("queue_drained", 64'(q_cyc.size()), 64'(0));
  endtask

  task automatic fill_pattern(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < A; c++)
        row_data[r][c] = DS'(16'h0100 * r + c);
  endtask

  task automatic fill_random(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < A; c++)
        row_data[r][c] = DS'($urandom);
  endtask

  initial begin
    int d, n, rk;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    fill_pattern(3);
    run_drain(2, 3, 10'h010, 1'b0, -1, -1);

    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("idle_rst");
    @(negedge clk);
    rst = 1'b0;

    row_data[0][0] = 16'hFFF0; row_data[0][1] = 16'h0005;
    row_data[0][2] = 16'h8000; row_data[0][3] = 16'h7FFF;
    run_drain(1, 1, 10'h020, 1'b1, -1, -1);
    run_drain(0, 1, 10'h021, 1'b0, -1, -1);

    fill_random(3);
    run_drain(1, 3, 10'h3FE, 1'b0, -1, -1);

    run_drain(3, 0, 10'h100, 1'b0, -1, -1);

    fill_pattern(3);
    run_drain(2, 3, 10'h010, 1'b0, 3, -1);

    fill_random(2);
    run_drain(1, 2, 10'h040, 1'b1, 1 + 2 + A, -1);

    fill_pattern(3);
    run_drain(2, 3, 10'h010, 1'b0, -1, 7);
    run_drain(2, 3, 10'h010, 1'b0, -1, -1);

    for (int i = 0; i < 20; i++) begin
      d = $urandom_range(0, 12);
      n = $urandom_range(0, 10);
      rk = (n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, d + n + A) : -1;
      fill_random(n);
      run_drain(d, n, AW'($urandom), 1'($urandom), rk, -1);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
